// File: rtl/cc_regs_pkg.sv
// ============================================================================
// Module      : cc_regs_pkg
// Description : ChronoCube register map, access codes and mask helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cc_regs_pkg;

    // ChronoCube register addresses
    localparam int unsigned CC_MAIN_CTRL = 'h00;
    localparam int unsigned CC_X_POS     = 'h08;
    localparam int unsigned CC_Y_POS     = 'h09;
    localparam int unsigned CC_X_OFFSET  = 'h0c;
    localparam int unsigned CC_Y_OFFSET  = 'h0d;

    // Implemented bits per register
    localparam int unsigned CC_MAIN_CTRL_BITS = 5;
    localparam int unsigned CC_POS_BITS       = 10;
    localparam int unsigned CC_OFFSET_BITS    = 10;

    // Classic map geometry: 16 registers of 16 bits
    localparam int unsigned CC_ADDR_WIDTH = 4;
    localparam int unsigned CC_DATA_WIDTH = 16;
    localparam int unsigned CC_NUM_REGS   = 1 << CC_ADDR_WIDTH;

    // Positions come from the core, offsets are latched at frame boundaries
    localparam logic [CC_NUM_REGS-1:0] CC_RO_MASK =
        CC_NUM_REGS'((1 << CC_X_POS) | (1 << CC_Y_POS));
    localparam logic [CC_NUM_REGS-1:0] CC_DB_MASK =
        CC_NUM_REGS'((1 << CC_X_OFFSET) | (1 << CC_Y_OFFSET));

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_ERR   = 2'd3
    } acc_e;

    function automatic logic [CC_DATA_WIDTH-1:0] cc_lsb_ones(input int unsigned bits);
        return CC_DATA_WIDTH'((32'd1 << bits) - 32'd1);
    endfunction

    function automatic logic [CC_NUM_REGS*CC_DATA_WIDTH-1:0] cc_width_mask();
        logic [CC_NUM_REGS*CC_DATA_WIDTH-1:0] m;
        m = '0;
        m[CC_MAIN_CTRL*CC_DATA_WIDTH +: CC_DATA_WIDTH] = cc_lsb_ones(CC_MAIN_CTRL_BITS);
        m[CC_X_POS*CC_DATA_WIDTH     +: CC_DATA_WIDTH] = cc_lsb_ones(CC_POS_BITS);
        m[CC_Y_POS*CC_DATA_WIDTH     +: CC_DATA_WIDTH] = cc_lsb_ones(CC_POS_BITS);
        m[CC_X_OFFSET*CC_DATA_WIDTH  +: CC_DATA_WIDTH] = cc_lsb_ones(CC_OFFSET_BITS);
        m[CC_Y_OFFSET*CC_DATA_WIDTH  +: CC_DATA_WIDTH] = cc_lsb_ones(CC_OFFSET_BITS);
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cc_reg_slot.sv
// ============================================================================
// Module      : cc_reg_slot
// Description : One register: byte-lane staging plus optional DB active copy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_reg_slot #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] MASK        = '1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter bit                    IS_DB       = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    commit_i,
    output logic [DATA_WIDTH-1:0]   staging_o,
    output logic [DATA_WIDTH-1:0]   active_o
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] RST_VAL = RESET_VALUE & MASK;

    logic [DATA_WIDTH-1:0] staging_d;
    logic [DATA_WIDTH-1:0] staging_q;

    always_comb begin
        staging_d = staging_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (wr_en_i && be_i[k]) begin
                staging_d[8*k +: 8] = wdata_i[8*k +: 8] & MASK[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) staging_q <= RST_VAL;
        else       staging_q <= staging_d;
    end

    assign staging_o = staging_q;

    generate
        if (IS_DB) begin : g_db
            logic [DATA_WIDTH-1:0] active_q;
            // Copies the pre-write staging value when write and commit coincide
            always_ff @(posedge clk) begin
                if (reset)         active_q <= RST_VAL;
                else if (commit_i) active_q <= staging_q;
            end
            assign active_o = active_q;
        end else begin : g_direct
            logic unused_commit;
            assign unused_commit = commit_i;
            assign active_o      = staging_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/cc_reg_file.sv
// ============================================================================
// Module      : cc_reg_file
// Description : ChronoCube control-register file: decode, read mux, strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_reg_file
    import cc_regs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH,
    localparam int unsigned NBYTES    = DATA_WIDTH / 8,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] WIDTH_MASK   = '1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0,
    parameter logic [NUM_REGS-1:0]            RO_MASK      = '0,
    parameter logic [NUM_REGS-1:0]            DB_MASK      = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           rd,
    input  logic                           wr,
    input  logic [NBYTES-1:0]              be,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           rd_valid,
    output logic                           bus_err,
    input  logic                           commit,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] values_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] values_out,
    output logic [NUM_REGS-1:0]            wr_strobe
);

    localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

    acc_e                  acc;
    logic [DATA_WIDTH-1:0] staging_w [NUM_REGS];
    logic [DATA_WIDTH-1:0] active_w  [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] data_out_d,  data_out_q;
    logic                  rd_valid_d,  rd_valid_q;
    logic                  bus_err_d,   bus_err_q;
    logic [NUM_REGS-1:0]   wr_strobe_d, wr_strobe_q;

    // Simultaneous rd+wr and writes to read-only slots both collapse to ACC_ERR
    always_comb begin
        acc = ACC_NONE;
        if (en) begin
            if (rd && wr)  acc = ACC_ERR;
            else if (wr)   acc = RO_MASK[addr] ? ACC_ERR : ACC_WRITE;
            else if (rd)   acc = ACC_READ;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
            cc_reg_slot #(
                .DATA_WIDTH  (DATA_WIDTH),
                .MASK        (WIDTH_MASK[i*DATA_WIDTH +: DATA_WIDTH]),
                .RESET_VALUE (RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH]),
                .IS_DB       (DB_MASK[i] && !RO_MASK[i])
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .wr_en_i   ((acc == ACC_WRITE) && (addr == ADDR_WIDTH'(i))),
                .be_i      (be),
                .wdata_i   (data_in),
                .commit_i  (commit),
                .staging_o (staging_w[i]),
                .active_o  (active_w[i])
            );
            assign values_out[i*DATA_WIDTH +: DATA_WIDTH] =
                RO_MASK[i] ? '0 : active_w[i];
        end
    endgenerate

    always_comb begin
        if (RO_MASK[addr])
            rd_word = values_in[addr*DATA_WIDTH +: DATA_WIDTH]
                    & WIDTH_MASK[addr*DATA_WIDTH +: DATA_WIDTH];
        else
            rd_word = staging_w[addr];
    end

    always_comb begin
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        bus_err_d   = 1'b0;
        wr_strobe_d = '0;
        case (acc)
            ACC_READ: begin
                data_out_d = rd_word;
                rd_valid_d = 1'b1;
            end
            ACC_WRITE: wr_strobe_d = ONE_HOT0 << addr;
            ACC_ERR:   bus_err_d   = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            wr_strobe_q <= '0;
        end else begin
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            bus_err_q   <= bus_err_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign bus_err   = bus_err_q;
    assign wr_strobe = wr_strobe_q;

endmodule

`default_nettype wire
